// File: rtl/seven_seg_scanner_if.sv
// Bus between the segment-encoding logic and the display scanner.
//   en          scan enable (1 = run, 0 = freeze counters and darken display)
//   in_seg      active-low segment patterns, digit k at [7k+6:7k]
//   dp_in       1 = light the decimal point of digit k
//   blank_in    1 = keep digit k dark
//   brightness  0 = dark, all-ones = full on, else duty brightness/2^BRIGHT_W
//   out_seg     active-low segment pins
//   dp          active-low decimal point pin
//   an          active-low anode pins (one low, or all high)
//   digit_idx   digit index of the current slot
//   frame_tick  one-cycle pulse at the start of each digit-0 slot
// master: the logic feeding the scanner. slave: the scanner itself.
interface seven_seg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BRIGHT_W   = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                    en;
  logic [7*NUM_DIGITS-1:0] in_seg;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [BRIGHT_W-1:0]     brightness;
  logic [6:0]              out_seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_tick;

  modport master (
    output en, in_seg, dp_in, blank_in, brightness,
    input  out_seg, dp, an, digit_idx, frame_tick
  );

  modport slave (
    input  en, in_seg, dp_in, blank_in, brightness,
    output out_seg, dp, an, digit_idx, frame_tick
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// Each digit owns a slot of PRESCALE clocks; the first DEAD_CYCLES of a slot
// keep every anode off to stop ghosting. The anode is further gated by the
// per-digit blank bit and a free-running PWM counter for brightness.
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous, active-high reset
//   bus  seven_seg_scanner_if.slave (data/control in, display pins out)
// All pin outputs are registered from the current counter state, so they lag
// the internal counters by one cycle; digit_idx is the internal register.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned PRESCALE    = 100000,
  parameter int unsigned DEAD_CYCLES = 16,
  parameter int unsigned BRIGHT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_scanner_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W:0]   DEAD_V   = (CNT_W + 1)'(DEAD_CYCLES);

  typedef enum logic {
    S_BLANK,
    S_ON
  } slot_state_e;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [BRIGHT_W-1:0]   pwm_cnt;
  logic [6:0]            lat_seg;
  logic                  lat_dp;
  logic                  lat_blank;
  logic [6:0]            out_seg;
  logic                  dp;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_tick;

  logic                  wrap;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic                  do_latch;
  logic [6:0]            cur_seg;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  lit;
  logic [NUM_DIGITS-1:0] an_on;
  slot_state_e           slot_state;

  always_comb begin
    wrap     = (cnt == CNT_LAST);
    cnt_nxt  = wrap ? '0 : cnt + 1'b1;
    idx_nxt  = digit_idx;
    if (wrap) begin
      idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
    end

    // Latch on the wrap edge for the incoming digit, and again whenever cnt
    // sits at 0, which covers the first enabled edge after reset and a resume
    // from a freeze held at cnt==0.
    do_latch = bus.en && (wrap || cnt == '0);

    // At cnt==0 the latch is loading on this very edge, so the slot's first
    // output must come straight from the inputs (matters when DEAD_CYCLES==0).
    cur_seg   = lat_seg;
    cur_dp    = lat_dp;
    cur_blank = lat_blank;
    if (cnt == '0) begin
      cur_seg   = bus.in_seg[7*digit_idx +: 7];
      cur_dp    = bus.dp_in[digit_idx];
      cur_blank = bus.blank_in[digit_idx];
    end

    slot_state = ({1'b0, cnt} < DEAD_V) ? S_BLANK : S_ON;

    lit = !cur_blank && ((bus.brightness == '1) || (pwm_cnt < bus.brightness));

    an_on = '1;
    an_on[digit_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      digit_idx  <= '0;
      pwm_cnt    <= '0;
      lat_seg    <= '1;
      lat_dp     <= 1'b0;
      lat_blank  <= 1'b1;
      out_seg    <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else if (!bus.en) begin
      out_seg    <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      digit_idx  <= idx_nxt;
      pwm_cnt    <= pwm_cnt + 1'b1;
      frame_tick <= (digit_idx == '0) && (cnt == '0);

      if (do_latch) begin
        lat_seg   <= bus.in_seg[7*idx_nxt +: 7];
        lat_dp    <= bus.dp_in[idx_nxt];
        lat_blank <= bus.blank_in[idx_nxt];
      end

      case (slot_state)
        S_BLANK: begin
          out_seg <= 7'h7F;
          dp      <= 1'b1;
          an      <= '1;
        end
        S_ON: begin
          out_seg <= cur_seg;
          dp      <= ~cur_dp;
          an      <= lit ? an_on : '1;
        end
        default: begin
          out_seg <= 7'h7F;
          dp      <= 1'b1;
          an      <= '1;
        end
      endcase
    end
  end

  assign bus.out_seg    = out_seg;
  assign bus.dp         = dp;
  assign bus.an         = an;
  assign bus.digit_idx  = digit_idx;
  assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with NUM_DIGITS=4, PRESCALE=8,
// DEAD_CYCLES=2, BRIGHT_W=2. t counts enabled edges since reset; the pins
// seen after an edge reflect the counter state before that edge.
module tb_seven_seg_scanner;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int unsigned t = 0;
  int unsigned tb_t = 0;
  logic [6:0] seg_tab [4];

  seven_seg_scanner_if #(.NUM_DIGITS(4), .BRIGHT_W(2)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS (4),
    .PRESCALE   (8),
    .DEAD_CYCLES(2),
    .BRIGHT_W   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    tb_t = t;
    @(posedge clk);
    #1;
    if (rst) t = 0;
    else if (bus.en) t = t + 1;
  endtask

  // Expected {frame_tick, an, out_seg, dp} after an enabled edge taken at count tt.
  function automatic logic [12:0] model(input int unsigned tt);
    int unsigned c;
    int unsigned d;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    logic       f;
    c = tt % 8;
    d = (tt / 8) % 4;
    a = 4'hF;
    s = 7'h7F;
    p = 1'b1;
    f = (c == 0) && (d == 0);
    if (c >= 2) begin
      s = seg_tab[d];
      p = ~bus.dp_in[d];
      if (!bus.blank_in[d] && (bus.brightness == 2'd3 || (tt % 4) < bus.brightness))
        a[d] = 1'b0;
    end
    return {f, a, s, p};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if ({bus.an, bus.out_seg, bus.dp, bus.digit_idx, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset: got an=%h seg=%h dp=%b idx=%0d ft=%b, expected an=f seg=7f dp=1 idx=0 ft=0",
               bus.an, bus.out_seg, bus.dp, bus.digit_idx, bus.frame_tick);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_scan();
    logic [12:0] got;
    logic [12:0] exp;
    int ticks = 0;
    bus.in_seg = {7'h30, 7'h12, 7'h24, 7'h79};
    seg_tab[0] = 7'h79; seg_tab[1] = 7'h24; seg_tab[2] = 7'h12; seg_tab[3] = 7'h30;
    bus.brightness = 2'd3;
    bus.en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp = model(tb_t);
      got = {bus.frame_tick, bus.an, bus.out_seg, bus.dp};
      if (bus.frame_tick) ticks++;
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL scan pins @t=%0d: got %h expected %h", tb_t, got, exp);
      end
      tests++;
      if (bus.digit_idx !== 2'((t / 8) % 4)) begin
        fails++;
        $display("FAIL scan digit_idx @t=%0d: got %0d expected %0d", tb_t, bus.digit_idx, (t / 8) % 4);
      end
    end
    tests++;
    if (ticks != 1) begin
      fails++;
      $display("FAIL frame_tick count: got %0d expected 1", ticks);
    end
  endtask

  task automatic test_blank_dp();
    logic [12:0] got;
    logic [12:0] exp;
    int dp_low = 0;
    bus.blank_in = 4'b0100;
    bus.dp_in    = 4'b0010;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp = model(tb_t);
      got = {bus.frame_tick, bus.an, bus.out_seg, bus.dp};
      if (!bus.dp) dp_low++;
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL blank_dp pins @t=%0d: got %h expected %h", tb_t, got, exp);
      end
      tests++;
      if (((tb_t / 8) % 4 == 2) && bus.an !== 4'hF) begin
        fails++;
        $display("FAIL blank digit2 an @t=%0d: got %h expected f", tb_t, bus.an);
      end
    end
    tests++;
    if (dp_low != 6) begin
      fails++;
      $display("FAIL dp low cycles: got %0d expected 6", dp_low);
    end
    bus.blank_in = 4'b0000;
    bus.dp_in    = 4'b0000;
  endtask

  task automatic test_brightness();
    logic [12:0] got;
    logic [12:0] exp;
    int lows;
    for (int b = 1; b >= 0; b--) begin
      bus.brightness = 2'(b);
      lows = 0;
      for (int i = 0; i < 32; i++) begin
        tick();
        exp = model(tb_t);
        got = {bus.frame_tick, bus.an, bus.out_seg, bus.dp};
        if (bus.an !== 4'hF) lows++;
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL bright%0d pins @t=%0d: got %h expected %h", b, tb_t, got, exp);
        end
      end
      tests++;
      if (lows != ((b == 1) ? 4 : 0)) begin
        fails++;
        $display("FAIL bright%0d anode-low cycles: got %0d expected %0d", b, lows, (b == 1) ? 4 : 0);
      end
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_enable_freeze();
    logic [12:0] got;
    logic [12:0] exp;
    // t=128 here: advance to internal cnt=5 of digit 1 (t%32 == 13)
    for (int i = 0; i < 13; i++) tick();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if ({bus.frame_tick, bus.an, bus.out_seg, bus.dp, bus.digit_idx} !== {1'b0, 4'hF, 7'h7F, 1'b1, 2'd1}) begin
        fails++;
        $display("FAIL freeze @%0d: got ft=%b an=%h seg=%h dp=%b idx=%0d expected ft=0 an=f seg=7f dp=1 idx=1",
                 i, bus.frame_tick, bus.an, bus.out_seg, bus.dp, bus.digit_idx);
      end
    end
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({bus.an, bus.out_seg, bus.digit_idx} !== {4'b1101, 7'h24, (i == 2) ? 2'd2 : 2'd1}) begin
        fails++;
        $display("FAIL resume @%0d: got an=%h seg=%h idx=%0d expected an=d seg=24 idx=%0d",
                 i, bus.an, bus.out_seg, bus.digit_idx, (i == 2) ? 2 : 1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = model(tb_t);
      got = {bus.frame_tick, bus.an, bus.out_seg, bus.dp};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL after resume @t=%0d: got %h expected %h", tb_t, got, exp);
      end
    end
  endtask

  task automatic test_mid_change_reset();
    logic [12:0] got;
    logic [12:0] exp;
    // advance to internal cnt=4 of digit 1 (t%32 == 12)
    while (t % 32 != 12) tick();
    bus.in_seg[13:7] = 7'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if ({bus.an, bus.out_seg} !== {4'b1101, 7'h24}) begin
        fails++;
        $display("FAIL mid-change stale @%0d: got an=%h seg=%h expected an=d seg=24", i, bus.an, bus.out_seg);
      end
    end
    seg_tab[1] = 7'h00;
    // run to internal cnt=6 of digit 3 (t%32 == 30), through the next digit-1 slot
    while (t % 32 != 30) begin
      tick();
      exp = model(tb_t);
      got = {bus.frame_tick, bus.an, bus.out_seg, bus.dp};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL mid-change pins @t=%0d: got %h expected %h", tb_t, got, exp);
      end
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({bus.an, bus.out_seg, bus.dp, bus.digit_idx, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
      fails++;
      $display("FAIL mid-slot reset: got an=%h seg=%h dp=%b idx=%0d ft=%b, expected an=f seg=7f dp=1 idx=0 ft=0",
               bus.an, bus.out_seg, bus.dp, bus.digit_idx, bus.frame_tick);
    end
    rst = 1'b0;
    tick();
    exp = model(tb_t);
    got = {bus.frame_tick, bus.an, bus.out_seg, bus.dp};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL first edge after reset: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.in_seg     = '0;
    bus.dp_in      = '0;
    bus.blank_in   = '0;
    bus.brightness = '0;
    test_reset();
    test_full_scan();
    test_blank_dp();
    test_brightness();
    test_enable_freeze();
    test_mid_change_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
